// File: rtl/debug_ctrl.sv
// Run-control unit: gates the clock enable and reset of a debugged DUT under RUN/HALT/STEP/DUT_RESET commands.
// Build with DEBUG_CTRL_BREAKPOINT_EN defined so that bp_hit can stop RUN or STEP.
module debug_ctrl #(
  parameter int STEP_W     = 16,
  parameter int CNT_W      = 32,
  parameter int RST_CYCLES = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [3:0]        cmd_op,
  input  logic [STEP_W-1:0] cmd_arg,
  input  logic              bp_hit,
  output logic              dut_clk_en,
  output logic              dut_rst,
  output logic              done,
  output logic [1:0]        status,
  output logic              running,
  output logic [CNT_W-1:0]  cycle_count
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_STEP, S_DRST} state_t;

  localparam logic [3:0] OP_NOP  = 4'd0;
  localparam logic [3:0] OP_RUN  = 4'd1;
  localparam logic [3:0] OP_HALT = 4'd2;
  localparam logic [3:0] OP_STEP = 4'd3;
  localparam logic [3:0] OP_DRST = 4'd4;

  localparam logic [1:0] ST_OK  = 2'd0;
  localparam logic [1:0] ST_BP  = 2'd1;
  localparam logic [1:0] ST_ILL = 2'd2;

  localparam logic [7:0] RST_LAST = 8'(RST_CYCLES - 1);

  state_t            state;
  logic [STEP_W-1:0] step_rem;
  logic [7:0]        rst_rem;
  logic              accept;
  logic              bp_act;

  assign accept = cmd_valid && cmd_ready;

`ifdef DEBUG_CTRL_BREAKPOINT_EN
  assign bp_act = bp_hit;
`else
  assign bp_act = bp_hit & 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= S_IDLE;
      dut_clk_en  <= 1'b0;
      dut_rst     <= 1'b1;
      done        <= 1'b0;
      status      <= ST_OK;
      running     <= 1'b0;
      cycle_count <= '0;
      cmd_ready   <= 1'b0;
      step_rem    <= '0;
      rst_rem     <= '0;
    end else begin
      done <= 1'b0;
      if (dut_clk_en) cycle_count <= cycle_count + CNT_W'(1);
      case (state)
        S_IDLE: begin
          dut_rst   <= 1'b0;
          cmd_ready <= 1'b1;
          if (accept) begin
            cmd_ready <= 1'b0;
            done      <= 1'b1;
            status    <= ST_OK;
            case (cmd_op)
              OP_NOP, OP_HALT: ;
              OP_RUN: begin
                state      <= S_RUN;
                running    <= 1'b1;
                dut_clk_en <= 1'b1;
              end
              OP_STEP: begin
                // remaining count is pre-decremented; a zero argument acts as one step
                done       <= 1'b0;
                state      <= S_STEP;
                running    <= 1'b1;
                dut_clk_en <= 1'b1;
                step_rem   <= (cmd_arg == '0) ? '0 : cmd_arg - STEP_W'(1);
              end
              OP_DRST: begin
                done        <= 1'b0;
                state       <= S_DRST;
                dut_rst     <= 1'b1;
                rst_rem     <= RST_LAST;
                cycle_count <= '0;
              end
              default: status <= ST_ILL;
            endcase
          end
        end
        S_RUN: begin
          cmd_ready <= 1'b1;
          if (bp_act) begin
            state      <= S_IDLE;
            running    <= 1'b0;
            dut_clk_en <= 1'b0;
            done       <= 1'b1;
            status     <= ST_BP;
            cmd_ready  <= 1'b0;
          end else if (accept) begin
            cmd_ready <= 1'b0;
            done      <= 1'b1;
            status    <= ST_OK;
            case (cmd_op)
              OP_NOP, OP_RUN: ;
              OP_HALT: begin
                state      <= S_IDLE;
                running    <= 1'b0;
                dut_clk_en <= 1'b0;
              end
              default: status <= ST_ILL;
            endcase
          end
        end
        S_STEP: begin
          cmd_ready <= 1'b0;
          if (bp_act || step_rem == '0) begin
            state      <= S_IDLE;
            running    <= 1'b0;
            dut_clk_en <= 1'b0;
            done       <= 1'b1;
            status     <= bp_act ? ST_BP : ST_OK;
          end else begin
            step_rem <= step_rem - STEP_W'(1);
          end
        end
        S_DRST: begin
          cmd_ready <= 1'b0;
          if (rst_rem == '0) begin
            state   <= S_IDLE;
            dut_rst <= 1'b0;
            done    <= 1'b1;
            status  <= ST_OK;
          end else begin
            rst_rem <= rst_rem - 8'd1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
